// File: rtl/ahb_sram_param.sv
// AHB-Lite SRAM slave with configurable bus width, read/write wait states,
// read-only mode, two-cycle ERROR responses and same-word write-to-read forwarding.
module ahb_sram_param #(
   parameter int RAM_SIZE   = 65536,
   parameter int DATA_WIDTH = 32,
   parameter int WAIT_RD    = 0,
   parameter int WAIT_WR    = 0,
   parameter bit READ_ONLY  = 1'b0
) (
   input  logic                  CLK,
   input  logic                  RES,
   input  logic                  S_HSEL,
   input  logic [1:0]            S_HTRANS,
   input  logic                  S_HWRITE,
   input  logic                  S_HMASTLOCK,
   input  logic [2:0]            S_HBURST,
   input  logic [3:0]            S_HPROT,
   input  logic [2:0]            S_HSIZE,
   input  logic [31:0]           S_HADDR,
   input  logic [DATA_WIDTH-1:0] S_HWDATA,
   input  logic                  S_HREADY,
   output logic                  S_HREADYOUT,
   output logic [DATA_WIDTH-1:0] S_HRDATA,
   output logic                  S_HRESP
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int LB    = $clog2(NB);
   localparam int AW    = $clog2(RAM_SIZE);
   localparam int IW    = AW - LB;
   localparam int WORDS = RAM_SIZE / NB;

   typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, ERR1, ERR2} state_t;

   state_t                state_p1, state_n;
   logic [3:0]            cnt_p1, cnt_n;
   logic                  dp_rd_p1, dp_rd_n;
   logic                  dp_wr_p1, dp_wr_n;
   logic [IW-1:0]         widx_p1;
   logic [NB-1:0]         wmask_p1;
   logic [DATA_WIDTH-1:0] rdata_p1;

   logic [IW-1:0]         a_idx;
   logic [LB-1:0]         a_off;
   logic [NB-1:0]         a_mask;
   logic                  a_bad;
   logic                  accept;
   logic                  done;
   logic                  ready;
   logic                  commit;
   logic [DATA_WIDTH-1:0] fwd_word;
   logic                  unused_bits;

   logic [DATA_WIDTH-1:0] mem [WORDS];

   // Oversized, misaligned, or (in read-only mode) any write is rejected.
   function automatic logic illegal_xfer(input logic [2:0] size, input logic [LB-1:0] off,
                                         input logic wr);
      logic bad;
      bad = (int'(size) > LB);
      for (int k = 0; k < LB; k++)
         if ((k < int'(size)) && off[k]) bad = 1'b1;
      if (wr && READ_ONLY) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [LB-1:0] off);
      logic [NB-1:0] m;
      int            lo;
      int            hi;
      lo = int'(off);
      hi = lo + (1 << size);
      for (int k = 0; k < NB; k++)
         m[k] = (k >= lo) && (k < hi);
      return m;
   endfunction

   assign unused_bits = ^{S_HMASTLOCK, S_HBURST, S_HPROT, S_HTRANS[0], S_HADDR[31:AW]};

   assign a_idx  = S_HADDR[AW-1:LB];
   assign a_off  = S_HADDR[LB-1:0];
   assign a_mask = lane_mask(S_HSIZE, a_off);
   assign a_bad  = illegal_xfer(S_HSIZE, a_off, S_HWRITE);

   assign ready  = (state_p1 == ERR1) ? 1'b0 :
                   ((state_p1 == RD_WAIT) || (state_p1 == WR_WAIT)) ? (cnt_p1 == 4'd0) : 1'b1;
   assign done   = ready & S_HREADY;
   assign accept = S_HSEL & S_HTRANS[1] & S_HREADY & ready;
   assign commit = dp_wr_p1 & done;

   assign S_HREADYOUT = ready;
   assign S_HRDATA    = (dp_rd_p1 && ready) ? rdata_p1 : '0;

   // A read accepted on the edge where a write to the same word commits
   // must see the new lanes, since the array still holds the old value.
   always_comb begin
      fwd_word = mem[a_idx];
      for (int k = 0; k < NB; k++)
         if (commit && (widx_p1 == a_idx) && wmask_p1[k])
            fwd_word[8*k +: 8] = S_HWDATA[8*k +: 8];
   end

   always_comb begin
      state_n = state_p1;
      cnt_n   = cnt_p1;
      dp_rd_n = dp_rd_p1;
      dp_wr_n = dp_wr_p1;
      S_HRESP = (state_p1 == ERR1) || (state_p1 == ERR2);
      if (done) begin
         state_n = IDLE;
         cnt_n   = 4'd0;
         dp_rd_n = 1'b0;
         dp_wr_n = 1'b0;
         if (accept) begin
            if (a_bad) begin
               state_n = ERR1;
            end else if (S_HWRITE) begin
               dp_wr_n = 1'b1;
               if (WAIT_WR != 0) begin
                  state_n = WR_WAIT;
                  cnt_n   = 4'(WAIT_WR);
               end
            end else begin
               dp_rd_n = 1'b1;
               if (WAIT_RD != 0) begin
                  state_n = RD_WAIT;
                  cnt_n   = 4'(WAIT_RD);
               end
            end
         end
      end else begin
         case (state_p1)
            RD_WAIT, WR_WAIT: if (cnt_p1 != 4'd0) cnt_n = cnt_p1 - 4'd1;
            ERR1:             state_n = ERR2;
            default:          ;
         endcase
      end
   end

   // ---- address phase -> data phase boundary ----
   always_ff @(posedge CLK) begin
      if (RES) begin
         state_p1 <= IDLE;
         cnt_p1   <= 4'd0;
         dp_rd_p1 <= 1'b0;
         dp_wr_p1 <= 1'b0;
      end else begin
         state_p1 <= state_n;
         cnt_p1   <= cnt_n;
         dp_rd_p1 <= dp_rd_n;
         dp_wr_p1 <= dp_wr_n;
      end
   end

   always_ff @(posedge CLK) begin
      if (accept && !a_bad) begin
         widx_p1  <= a_idx;
         wmask_p1 <= a_mask;
         rdata_p1 <= fwd_word;
      end
   end

   // ---- data phase end: write commit ----
   always_ff @(posedge CLK) begin
      if (commit && !RES) begin
         for (int k = 0; k < NB; k++)
            if (wmask_p1[k]) mem[widx_p1][8*k +: 8] <= S_HWDATA[8*k +: 8];
      end
   end

endmodule
